// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder of two WIDTH-bit operands.
// One operand bit pair is consumed per clock, LSB first, using a single
// full-adder cell and a carry flop. A result is produced WIDTH edges after
// the start-accepting edge; sum and cout are registered and hold until the
// next completion. Control flows IDLE -> SHIFT (WIDTH cycles) -> DONE -> IDLE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must hold WIDTH itself, so it never wraps during an operation.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Full-adder sum bit.
    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    // Full-adder carry: majority of the three inputs.
    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             bit_s;
    logic             carry_nxt_s;
    logic             last_s;

    // Next-state and datapath logic for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_d       = res_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        cnt_d       = cnt_q;

        bit_s       = fa_sum(a_sh_q[0], b_sh_q[0], carry_q);
        carry_nxt_s = fa_carry(a_sh_q[0], b_sh_q[0], carry_q);
        last_s      = (cnt_q == CW'(WIDTH - 1));

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Result fills from the MSB so after WIDTH shifts bit 0 is the LSB.
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = carry_nxt_s;
                cnt_d   = cnt_q + CW'(1);
                if (last_s) begin
                    sum_d   = {bit_s, res_q[WIDTH-1:1]};
                    cout_d  = carry_nxt_s;
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                // start is deliberately ignored here; it is seen again in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered versions of the upcoming state.
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // State, datapath and registered outputs; async active-low reset clears all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for directed and
// random additions, and a 4-bit instance for an exhaustive operand sweep.
module tb_serial_adder;

    typedef struct {
        logic [32:0] res;   // {cout, sum} expected, plain a+b
        int          acc;   // cycle number of the accept edge
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start4;
    logic [7:0] a8, b8, sum8;
    logic [3:0] a4, b4, sum4;
    logic       busy8, done8, cout8;
    logic       busy4, done4, cout4;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q8[$];
    exp_t q4[$];
    logic [8:0] hold8 = '0;
    logic [4:0] hold4 = '0;
    int   busy_cnt8 = 0;
    int   busy_cnt4 = 0;
    int   last_done8 = 0;
    int   prev_done8 = 0;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    always #5 clk = ~clk;

    // Edge counter used to time-stamp accepts and completions.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 8-bit instance: pops the scoreboard on every done.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold8     = '0;
            busy_cnt8 = 0;
        end else begin
            if (busy8) busy_cnt8++;
            if (done8) begin
                if (q8.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL done8_unexpected: got done=1, expected no pending operation (cycle %0d)", cyc);
                end else begin
                    e = q8.pop_front();
                    chk("sum8", sum8, e.res[7:0]);
                    chk("cout8", cout8, e.res[8]);
                    chk("lat8", cyc, e.acc + 8);
                    chk("busy8_cycles", busy_cnt8, 8);
                    hold8 = e.res[8:0];
                end
                prev_done8 = last_done8;
                last_done8 = cyc;
                busy_cnt8  = 0;
            end else begin
                chk("hold8", {cout8, sum8}, hold8);
            end
        end
    end

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold4     = '0;
            busy_cnt4 = 0;
        end else begin
            if (busy4) busy_cnt4++;
            if (done4) begin
                if (q4.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL done4_unexpected: got done=1, expected no pending operation (cycle %0d)", cyc);
                end else begin
                    e = q4.pop_front();
                    chk("sum4_cout4", {cout4, sum4}, e.res[4:0]);
                    chk("lat4", cyc, e.acc + 4);
                    chk("busy4_cycles", busy_cnt4, 4);
                    hold4 = e.res[4:0];
                end
                busy_cnt4 = 0;
            end else begin
                chk("hold4", {cout4, sum4}, hold4);
            end
        end
    end

    // Called at a negedge while the 8-bit DUT is idle; returns at the
    // negedge of the first SHIFT cycle with operands scrambled.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        e.res = 33'(a) + 33'(b);
        e.acc = cyc + 1;
        q8.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    // Waits (bounded) until done8 is seen at a negedge.
    task automatic wait_done8();
        int k = 0;
        while (!done8 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done8) begin
            n_cmp++;
            n_err++;
            $display("FAIL done8_timeout: got no done, expected done within 40 cycles");
        end
    endtask

    task automatic add8(input logic [7:0] a, input logic [7:0] b);
        issue8(a, b);
        wait_done8();
        @(negedge clk);
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        a4 = a;
        b4 = b;
        start4 = 1'b1;
        e.res = 33'(a) + 33'(b);
        e.acc = cyc + 1;
        q4.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
    endtask

    task automatic add4(input logic [3:0] a, input logic [3:0] b);
        int k = 0;
        issue4(a, b);
        while (!done4 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done4) begin
            n_cmp++;
            n_err++;
            $display("FAIL done4_timeout: got no done, expected done within 20 cycles");
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        start8 = 1'b0;
        start4 = 1'b0;
        a8 = '0; b8 = '0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        chk("rst_outputs8", {busy8, done8, cout8, sum8}, 11'd0);
        chk("rst_outputs4", {busy4, done4, cout4, sum4}, 7'd0);

        // Release and start on the very first active edge.
        rst_n = 1'b1;
        add8(8'h00, 8'h00);
        add8(8'hFF, 8'h01);

        // Back-to-back: second start in the IDLE cycle right after DONE.
        issue8(8'hA5, 8'h5A);
        wait_done8();
        @(negedge clk);
        issue8(8'hFF, 8'hFF);
        wait_done8();
        chk("b2b_gap", last_done8 - prev_done8, 10);
        @(negedge clk);

        // start re-pulsed and operands changed while SHIFT, start also in DONE.
        issue8(8'h10, 8'h20);
        a8 = 8'hFF;
        b8 = 8'hFF;
        start8 = 1'b1;
        repeat (3) @(negedge clk);
        start8 = 1'b0;
        wait_done8();
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        chk("no_restart_busy", busy8, 1'b0);

        // Reset between edges after three SHIFT cycles.
        issue8(8'h77, 8'h99);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {busy8, done8, cout8, sum8}, 11'd0);
        q8.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        add8(8'h03, 8'h04);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            add8(8'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Exhaustive 4-bit sweep.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                add4(4'(x), 4'(y));
            end
        end

        repeat (5) @(negedge clk);
        chk("q8_drained", q8.size(), 0);
        chk("q4_drained", q4.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand and sum width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request to add a and b; sampled on rising clk edges only.
REQ-005 The block SHALL have port a, input, WIDTH bits: addend, sampled only on the edge that accepts start.
REQ-006 The block SHALL have port b, input, WIDTH bits: addend, sampled only on the edge that accepts start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when sum and cout are updated.
REQ-009 The block SHALL have port sum, output, WIDTH bits: registered result, a+b modulo 2^WIDTH.
REQ-010 The block SHALL have port cout, output, 1 bit: registered carry-out of the last addition.

Function
REQ-011 The block SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL latch a and b into operand shift registers, clear the carry register and bit counter, and enter SHIFT.
REQ-013 In IDLE with start=0, the block SHALL hold all state.
REQ-014 In each SHIFT cycle, the block SHALL compute bit = a_sh[0] ^ b_sh[0] ^ carry and next carry = majority(a_sh[0], b_sh[0], carry).
REQ-015 In each SHIFT cycle, the block SHALL shift the result register right with bit inserted at MSB, shift both operand registers right by one, and increment the counter.
REQ-016 Operands SHALL be processed LSB first.
REQ-017 On the edge completing the WIDTH-th SHIFT cycle, the block SHALL copy the result register to sum, copy the final carry to cout, and enter DONE.
REQ-018 The block SHALL go from DONE to IDLE unconditionally on the next edge.
REQ-019 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during an operation.
REQ-020 busy SHALL be 1 exactly when state is SHIFT.
REQ-021 done SHALL be 1 exactly when state is DONE: a single-cycle pulse.
REQ-022 done SHALL be high in the cycle following the edge that falls WIDTH edges after the start-accepting edge.
REQ-023 The block SHALL ignore start while in SHIFT or DONE: no restart, no operand resample, no error.
REQ-024 sum and cout SHALL change only on entry to DONE and SHALL hold their values through IDLE and SHIFT until the next completion.
REQ-025 A start asserted in the IDLE cycle immediately after DONE SHALL be accepted normally, giving back-to-back throughput of one result per WIDTH+2 cycles.
REQ-026 Changes on a or b after the start-accepting edge SHALL NOT affect the result in progress.

Reset
REQ-027 While rst_n=0, independent of clk, the block SHALL set state to IDLE, clear carry, counter and all shift registers, and drive busy=0, done=0, sum=0, cout=0.
REQ-028 Reset asserted mid-operation SHALL abort the addition with no done pulse and no update of sum or cout other than clearing them.
REQ-029 The first rising edge with rst_n=1 SHALL be able to accept start.

Verification
REQ-030 The bench SHALL cover, with WIDTH=8, a=0x00, b=0x00 and start pulsed: done pulses once, 8 edges after the accept edge, with sum=0x00, cout=0, and busy high for exactly 8 cycles.
REQ-031 The bench SHALL cover a=0xFF, b=0x01: sum=0x00, cout=1 (full carry ripple).
REQ-032 The bench SHALL cover a=0xA5, b=0x5A, then a=0xFF, b=0xFF back-to-back: sum=0xFF, cout=0, then sum=0xFE, cout=1, with the second done 10 cycles after the first.
REQ-033 The bench SHALL cover a=0x10, b=0x20 with start re-pulsed and a, b changed to 0xFF mid-SHIFT: result stays sum=0x30, cout=0, with a single done.
REQ-034 The bench SHALL cover rst_n driven low between clock edges after 3 SHIFT cycles: busy, done, sum and cout go to 0 immediately with no later done; a new start of 0x03+0x04 after release gives sum=0x07.
REQ-035 The bench SHALL cover an exhaustive sweep at WIDTH=4 of all 256 (a,b) pairs: {cout,sum} equals a+b for every pair.
